// File: rtl/rsa_crypt.sv
// rsa_crypt: square-and-multiply modular exponentiation, one key bit per cycle, fixed latency.
// Optional RSA_CRYPT_CHECK_EN adds out_err flagging a degenerate modulus or an unreduced message.
module rsa_crypt #(
  parameter int WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2*WIDTH-1:0]   in_n,
  input  logic [2*WIDTH-1:0]   in_key,
  input  logic [2*WIDTH-1:0]   in_msg,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   out_msg,
  output logic                 busy
`ifdef RSA_CRYPT_CHECK_EN
  , output logic               out_err
`endif
);
  localparam int M = 2 * WIDTH;
  localparam int CW = $clog2(M + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, OUT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [M-1:0]  n_q, n_d, key_q, key_d, base_q, base_d, acc_q, acc_d;
  logic [M-1:0]  out_msg_q, out_msg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;

  // Full double-width product; a zero modulus reduces everything to 0.
  function automatic logic [M-1:0] mulmod(input logic [M-1:0] a, input logic [M-1:0] b,
                                          input logic [M-1:0] n);
    logic [2*M-1:0] p;
    p = {{M{1'b0}}, a} * {{M{1'b0}}, b};
    p = (n == '0) ? '0 : p % {{M{1'b0}}, n};
    return p[M-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    key_d       = key_q;
    base_d      = base_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_msg_d   = '0;
    if (state_q == IDLE && in_valid) begin
      n_d     = in_n;
      key_d   = in_key;
      base_d  = (in_n == '0) ? '0 : in_msg % in_n;
      acc_d   = (in_n > M'(1)) ? M'(1) : '0;
      cnt_d   = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      acc_d   = key_q[0] ? mulmod(acc_q, base_q, n_q) : acc_q;
      base_d  = mulmod(base_q, base_q, n_q);
      key_d   = key_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      state_d = (cnt_q == CW'(M - 1)) ? OUT : CALC;
    end else if (state_q == OUT) begin
      out_valid_d = 1'b1;
      out_msg_d   = acc_q;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      key_q       <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_msg_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      key_q       <= key_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_msg_q   <= out_msg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_msg   = out_msg_q;
  assign busy      = (state_q != IDLE);

`ifdef RSA_CRYPT_CHECK_EN
  logic err_q, err_d, out_err_q, out_err_d;

  always_comb begin
    err_d     = (state_q == IDLE && in_valid) ? ((in_n < M'(2)) || (in_msg >= in_n)) : err_q;
    out_err_d = (state_q == OUT) ? err_q : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`endif
endmodule
